// File: rtl/pc_gen.sv
// Program-counter generator for the MIPS fetch stage: reset vector, branch/flush redirect,
// and buffering of a redirect that arrives while stalled. Optional check: PC_MISALIGN_CHK_EN.
module pc_gen #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    CTRL_WIDTH   = 6,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    INC          = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CTRL_WIDTH-1:0] stall,
  input  logic                  branch_valid,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_addr,
  output logic [ADDR_WIDTH-1:0] addr_to_rom,
  output logic                  pc_enable,
  output logic                  redirect_pending,
  output logic                  addr_misalign
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic                  pend_q, pend_d;
  logic                  load;
  logic [ADDR_WIDTH-1:0] load_addr;

  // Only stall[0] concerns the PC; the other bits belong to later stages.
  logic unused_stall;
  assign unused_stall = ^stall;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= RESET_VECTOR;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the block infers a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    load        = 1'b0;
    load_addr   = flush_addr;

    case (state_q)
      S_IDLE: begin
        // Redirects are ignored here; the first fetch always comes from the reset vector.
        state_d = S_RUN;
        addr_d  = RESET_VECTOR;
      end
      S_RUN: begin
        if (flush) begin
          load   = 1'b1;
          pend_d = 1'b0;
        end else if (stall[0]) begin
          if (branch_valid) begin
            pend_addr_d = branch_target;
            pend_d      = 1'b1;
          end
        end else if (branch_valid) begin
          load      = 1'b1;
          load_addr = branch_target;
          pend_d    = 1'b0;
        end else if (pend_q) begin
          load      = 1'b1;
          load_addr = pend_addr_q;
          pend_d    = 1'b0;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(INC);
        end
        if (load) addr_d = load_addr;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign addr_to_rom      = addr_q;
  assign pc_enable        = (state_q == S_RUN);
  assign redirect_pending = pend_q;

`ifdef PC_MISALIGN_CHK_EN
  logic misalign_q;

  // Registered alongside addr_q so the pulse lines up with the misaligned fetch address.
  always_ff @(posedge clk) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= load && (load_addr[1:0] != 2'b00);
  end

  assign addr_misalign = misalign_q;
`else
  assign addr_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios followed by randomized traffic,
// all compared against a cycle-level reference model of the next-PC rules.
module tb_pc_gen;

  localparam int          AW = 32;
  localparam int          CW = 6;
  localparam logic [31:0] RV = 32'h0000_0100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] stall;
  logic          branch_valid;
  logic [AW-1:0] branch_target;
  logic          flush;
  logic [AW-1:0] flush_addr;
  logic [AW-1:0] addr_to_rom;
  logic          pc_enable;
  logic          redirect_pending;
  logic          addr_misalign;

  pc_gen #(
    .ADDR_WIDTH  (AW),
    .CTRL_WIDTH  (CW),
    .RESET_VECTOR(RV),
    .INC         (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .branch_valid    (branch_valid),
    .branch_target   (branch_target),
    .flush           (flush),
    .flush_addr      (flush_addr),
    .addr_to_rom     (addr_to_rom),
    .pc_enable       (pc_enable),
    .redirect_pending(redirect_pending),
    .addr_misalign   (addr_misalign)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef PC_MISALIGN_CHK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  // Reference model state: what the fetch stage should look like after each edge.
  bit          m_run;
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_pend_addr;
  bit          m_mis;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void load_target(input logic [31:0] t);
    m_pc  = t;
    m_pend = 1'b0;
    m_mis = MIS_EN && (t % 4 != 0);
  endfunction

  // Apply the fetch rules to the inputs present at this edge.
  function automatic void model_edge();
    m_mis = 1'b0;
    if (!rst_n) begin
      m_run = 1'b0; m_pc = RV; m_pend = 1'b0; m_pend_addr = '0;
    end else if (!m_run) begin
      m_run = 1'b1; m_pc = RV;
    end else if (flush) begin
      load_target(flush_addr);
    end else if (stall[0]) begin
      if (branch_valid) begin
        m_pend = 1'b1; m_pend_addr = branch_target;
      end
    end else if (branch_valid) begin
      load_target(branch_target);
    end else if (m_pend) begin
      load_target(m_pend_addr);
    end else begin
      m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("pc_enable", 32'(pc_enable), 32'(m_run));
    check("addr", addr_to_rom, m_pc);
    check("pending", 32'(redirect_pending), 32'(m_pend));
    check("misalign", 32'(addr_misalign), 32'(m_mis));
  endtask

  task automatic idle_inputs();
    stall = '0; branch_valid = 1'b0; branch_target = '0; flush = 1'b0; flush_addr = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    m_run = 1'b0; m_pc = RV; m_pend = 1'b0; m_pend_addr = '0; m_mis = 1'b0;

    // Reset held for three edges, with noise on the redirect inputs.
    flush = 1'b1; flush_addr = 32'h0000_0777; branch_valid = 1'b1; branch_target = 32'h0000_0555;
    repeat (3) begin
      step();
      check("rst_en", 32'(pc_enable), 32'd0);
      check("rst_addr", addr_to_rom, RV);
    end
    idle_inputs();
    rst_n = 1'b1;
    step(); check("start_en", 32'(pc_enable), 32'd1); check("start_addr", addr_to_rom, 32'h100);
    step(); check("inc1", addr_to_rom, 32'h104);
    step(); check("inc2", addr_to_rom, 32'h108);

    // Stall holds the PC.
    flush = 1'b1; flush_addr = 32'h10; step(); flush = 1'b0;
    stall = 6'b000001; step(); step(); check("stall_hold", addr_to_rom, 32'h10);
    stall = 6'b111110; step(); check("stall_rel", addr_to_rom, 32'h14);
    stall = '0;

    // Branch while running.
    flush = 1'b1; flush_addr = 32'h20; step(); flush = 1'b0;
    branch_valid = 1'b1; branch_target = 32'h400; step(); check("br_run", addr_to_rom, 32'h400);
    branch_valid = 1'b0; step(); check("br_next", addr_to_rom, 32'h404);

    // Branch during stall, newer branch overwrites the pending one.
    stall = 6'b000001;
    branch_valid = 1'b1; branch_target = 32'h800; step();
    check("br_st_pend", 32'(redirect_pending), 32'd1); check("br_st_hold", addr_to_rom, 32'h404);
    branch_target = 32'h900; step();
    branch_valid = 1'b0; step(); check("br_st_hold2", addr_to_rom, 32'h404);
    stall = '0; step();
    check("br_st_rel", addr_to_rom, 32'h900); check("br_st_clr", 32'(redirect_pending), 32'd0);

    // Flush beats stall, a live branch and a pending redirect.
    stall = 6'b000001; branch_valid = 1'b1; branch_target = 32'h900; step();
    flush = 1'b1; flush_addr = 32'h180; branch_target = 32'h0A00; step();
    check("fl_addr", addr_to_rom, 32'h180); check("fl_pend", 32'(redirect_pending), 32'd0);
    flush = 1'b0; branch_valid = 1'b0; stall = '0; step();
    check("fl_next", addr_to_rom, 32'h184);

    // Wrap-around and misaligned branch.
    flush = 1'b1; flush_addr = 32'hFFFF_FFFC; step(); flush = 1'b0;
    step(); check("wrap", addr_to_rom, 32'h0);
    branch_valid = 1'b1; branch_target = 32'h402; step();
    check("mis_addr", addr_to_rom, 32'h402); check("mis_pulse", 32'(addr_misalign), 32'(MIS_EN));
    branch_valid = 1'b0; step(); check("mis_drop", 32'(addr_misalign), 32'd0);

    // Misaligned branch buffered during stall pulses only when loaded.
    stall = 6'b000001; branch_valid = 1'b1; branch_target = 32'h0000_0C01; step();
    check("mis_buf", 32'(addr_misalign), 32'd0);
    branch_valid = 1'b0; stall = '0; step();
    check("mis_pend", 32'(addr_misalign), 32'(MIS_EN));

    // Reset mid-operation discards a pending redirect.
    stall = 6'b000001; branch_valid = 1'b1; branch_target = 32'h2000; step();
    rst_n = 1'b0; step(); rst_n = 1'b1; idle_inputs(); step(); step();
    check("rst_discard", addr_to_rom, RV + 32'd4);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n         = ($urandom_range(99) != 0);
      stall         = CW'($urandom);
      stall[0]      = ($urandom_range(2) == 0);
      branch_valid  = ($urandom_range(5) == 0);
      branch_target = $urandom;
      if ($urandom_range(3) != 0) branch_target[1:0] = 2'b00;
      flush         = ($urandom_range(15) == 0);
      flush_addr    = ($urandom_range(7) == 0) ? 32'hFFFF_FFF8 : $urandom;
      if ($urandom_range(3) != 0) flush_addr[1:0] = 2'b00;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the MIPS fetch stage; next generation of the basic incrementing PC.
- Adds a configurable reset vector, branch/jump redirect, and an exception/flush redirect.
- Buffers a redirect that arrives while the PC is stalled and applies it when the stall releases.
- Drives the instruction-ROM address and the fetch-enable into IF.

Parameters:
ADDR_WIDTH, 32, width of the PC and all target addresses.
CTRL_WIDTH, 6, width of the pipeline stall vector; bit 0 stalls the PC.
RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
INC, 4, byte increment per sequential fetch.

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
stall  in  CTRL_WIDTH  pipeline stall vector; stall[0]=1 holds the PC
branch_valid  in  1  one-cycle redirect request from ID/EX
branch_target  in  ADDR_WIDTH  redirect target, sampled when branch_valid=1
flush  in  1  exception/eret redirect; highest priority, ignores stall
flush_addr  in  ADDR_WIDTH  flush target, sampled when flush=1
addr_to_rom  out  ADDR_WIDTH  current fetch address (registered)
pc_enable  out  1  fetch enable (registered)
redirect_pending  out  1  a stalled redirect is buffered (registered)
addr_misalign  out  1  one-cycle pulse when the PC is loaded with a target whose low 2 bits are non-zero (optional feature only)

Behaviour:
- Reset (rst_n=0 at an edge):
  - pc_enable=0, addr_to_rom=RESET_VECTOR, redirect_pending=0, pend_addr=0, addr_misalign=0.
  - Reset mid-operation discards any pending redirect.
- Start-up:
  - pc_enable rises at the first edge with rst_n=1.
  - While pc_enable=0, addr_to_rom is forced to RESET_VECTOR. This gives one cycle of pipe delay.
  - The first increment happens at the first edge with pc_enable=1 and stall[0]=0.
- Two states:
  - IDLE: pc_enable=0.
  - RUN: pc_enable=1.
  - IDLE->RUN on rst_n=1. Any state ->IDLE on rst_n=0.
  - In IDLE, flush and branch_valid are ignored.
- Next-PC priority in RUN, evaluated each edge:
  1. flush=1: addr_to_rom<=flush_addr; redirect_pending<=0. Applies even when stall[0]=1.
  2. stall[0]=1 and branch_valid=1: pend_addr<=branch_target; redirect_pending<=1; PC holds. A newer branch overwrites an older pending one.
  3. stall[0]=1, no branch: PC and pending state hold.
  4. stall[0]=0 and branch_valid=1: addr_to_rom<=branch_target; redirect_pending<=0. A live branch beats a stale pending one.
  5. stall[0]=0 and redirect_pending=1: addr_to_rom<=pend_addr; redirect_pending<=0.
  6. Otherwise: addr_to_rom<=addr_to_rom+INC.
- Arithmetic: the increment is modulo 2^ADDR_WIDTH. All-ones minus 3 plus 4 wraps to 0 with no flag.
- Redirect latency: a target presented at edge N appears on addr_to_rom after edge N.
- stall[CTRL_WIDTH-1:1] are not used by this block.

Optional Feature:
- Macro: PC_MISALIGN_CHK_EN.
- Defined:
  - addr_misalign pulses for exactly one cycle, registered together with addr_to_rom, whenever a flush, branch or pending target with [1:0]!=0 is loaded.
  - The PC still loads the address unchanged; the exception unit decides what to do.
  - A branch that is only buffered during stall does not pulse; the pulse comes when the target is loaded.
- Undefined: the addr_misalign port stays present, tied to 0, and no check logic is built.

Test Plan:
- Reset: rst_n=0 for 3 cycles, then 1, RESET_VECTOR=0x100 -> pc_enable=0, addr=0x100 during reset; edge 1 after release: pc_enable=1, addr=0x100; then 0x104, 0x108.
- Stall: stall[0]=1 for 2 cycles at addr=0x10 -> addr holds 0x10; after release -> 0x14.
- Branch while running: branch_valid=1, target=0x400 at addr 0x20 -> next addr=0x400, then 0x404.
- Branch during stall: stall[0]=1, branch to 0x800 -> redirect_pending=1, addr holds. Second branch to 0x900 while still stalled -> pending=0x900. Release -> addr=0x900, pending=0.
- Flush beats stall, branch and pending: stall[0]=1 with 0x900 pending; flush=1, flush_addr=0x180 with branch_valid=1 in the same cycle -> addr=0x180, pending=0. Release stall -> 0x184.
- Wrap and misalign (with PC_MISALIGN_CHK_EN defined):
  - addr=0xFFFF_FFFC -> next addr=0x0000_0000.
  - Branch to 0x402 -> addr=0x402 and addr_misalign=1 for one cycle.
  - Without the macro -> addr_misalign stays 0.
